prbs_seq_checker: RTL and testbench
===================================

# prbs_seq_checker

Receive-side checker that sits directly downstream of the PRBS-15 byte generator and consumes its byte stream. It hunts for a programmable 4-byte sequence and counts repetitions of it. When the required count is reached it arms on the first PRBS-15 byte, then checks every following byte against a local PRBS-15 model. It reports lock status, per-byte error pulses, saturating error and byte counters, and loss-of-lock/sync-fail events.

## Interface
- ERR_W, 16, width of error counter
- CNT_W, 24, width of checked-byte counter
- ARM_TIMEOUT, 8, max bytes spent in ARM before sync failure
- LOSS_THR, 8, consecutive mismatches in CHECK that drop lock

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- en  input  1  data_in valid this cycle; all state advances only when en=1
- data_in  input  8  byte stream from generator
- pattern  input  32  expected sequence, pattern[31:24] first byte
- n  input  2  required pattern repetitions; 0 treated as 1
- seq_detect  output  1  one-cycle pulse per pattern match
- locked  output  1  high while in CHECK
- err  output  1  one-cycle pulse on a mismatched byte in CHECK
- err_count  output  ERR_W  mismatches since lock, saturating
- byte_count  output  CNT_W  bytes checked since lock, saturating
- sync_fail  output  1  one-cycle pulse on ARM timeout or loss of lock

## Operation
- Shift window: 32-bit window = {window[23:0], data_in} on each en byte; fill counter 0..4 saturates at 4.
- Match = fill counter (including current byte) reaches 4 and the new window equals pattern. On a match the fill counter clears to 0, so the next match needs 4 fresh bytes. Once refilled, the window slides byte-by-byte.
- States: HUNT, SEQ, ARM, CHECK.
- HUNT: on first match, pulse seq_detect and set rep_cnt=1. If the required count is 1, go to ARM; otherwise go to SEQ. pattern and n are sampled only in HUNT and held thereafter.
- SEQ: each match pulses seq_detect and increments rep_cnt. When rep_cnt reaches the required count, go to ARM. Non-matching bytes, including generator hold bytes, are ignored.
- ARM: local model R[14:0] = 15'h7FFF; expected byte = {R[6:0], R[14]} = 8'hFF.
  - On data_in == expected: advance R once, clear counters, go to CHECK. The first byte is not counted.
  - Otherwise increment arm_cnt. On the ARM_TIMEOUT-th non-matching byte, pulse sync_fail and go to HUNT.
  - A pattern byte of 8'hFF can false-arm; this is accepted behaviour.
- CHECK: each byte is compared with {R[6:0], R[14]}, then R <= {R[13:0], R[14]^R[13]}.
  - byte_count increments, saturating at all-ones.
  - On a mismatch: pulse err, increment err_count (saturating) and increment miss_cnt. A matching byte clears miss_cnt.
  - When miss_cnt reaches LOSS_THR: pulse sync_fail, drop locked and go to HUNT. err_count and byte_count hold their values until the next ARM→CHECK entry.
- Leaving CHECK or ARM clears the window fill counter and rep_cnt.

## Timing
- All outputs are registered. A decision on the byte sampled at edge k appears on outputs after edge k.
- seq_detect, err and sync_fail are high for exactly one cycle. They are not re-asserted while en=0.
- locked rises in the cycle after the arming byte and falls in the cycle after the LOSS_THR-th miss.
- When en=0, all state, counters and the PRBS model hold. Pulses deassert.
- Reset (async, any state, mid-stream included): state=HUNT, window=0, fill=0, R=15'h7FFF, and every output is 0 (seq_detect, locked, err, err_count, byte_count, sync_fail).
- Simultaneous match and state change: the seq_detect pulse is always emitted, and the transition takes effect the same edge.

## Test plan
- pattern=32'hA5C33C5A, n=2, stream A5 C3 3C 5A A5 C3 3C 5A FF FD F9 … → two seq_detect pulses, then locked=1 after FF.
  - Thereafter err=0, err_count=0, byte_count increments per byte.
- Same setup with a hold byte: stream A5 C3 3C 5A 5A A5 C3 3C 5A, then PRBS → hold byte ignored, second match detected, lock achieved.
- In CHECK, corrupt the third PRBS byte (send F8 instead of F9) → single err pulse, err_count=1, locked stays 1.
  - Following correct bytes leave err_count unchanged.
- In CHECK, send 8 consecutive 00 bytes → 8 err pulses, err_count=8, sync_fail pulse, locked=0, state HUNT.
- After n=1 match, send 8 bytes of 12 (no FF) → sync_fail after the 8th byte, back to HUNT, locked never asserts.
- Assert rst mid-CHECK with err_count=3 → all outputs 0 immediately.
  - Full pattern/PRBS stream after release relocks from scratch.

Source files
------------

// File: rtl/prbs_seq_checker.sv
// Receive-side PRBS-15 checker: hunts for a repeated 4-byte pattern, arms on
// the first PRBS byte, then checks the stream against a local PRBS-15 model.
module prbs_seq_checker #(
    parameter int ERR_W       = 16,
    parameter int CNT_W       = 24,
    parameter int ARM_TIMEOUT = 8,
    parameter int LOSS_THR    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       data_in,
    input  logic [31:0]      pattern,
    input  logic [1:0]       n,
    output logic             seq_detect,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] byte_count,
    output logic             sync_fail
);

    localparam int AW = $clog2(ARM_TIMEOUT + 1);
    localparam int MW = $clog2(LOSS_THR + 1);
    localparam logic [AW-1:0] ARM_LAST  = AW'(ARM_TIMEOUT - 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(LOSS_THR - 1);
    localparam logic [14:0]   PRBS_SEED = 15'h7FFF;

    typedef enum logic [1:0] {HUNT, SEQ, ARM, CHECK} state_t;

    state_t            state, state_nx;
    logic [31:0]       window, window_nx;
    logic [2:0]        fill, fill_nx;
    logic [1:0]        rep_cnt, rep_cnt_nx;
    logic [31:0]       pat_q, pat_nx;
    logic [1:0]        req_q, req_nx;
    logic [AW-1:0]     arm_cnt, arm_cnt_nx;
    logic [MW-1:0]     miss_cnt, miss_cnt_nx;
    logic [14:0]       prbs, prbs_nx;
    logic [ERR_W-1:0]  err_count_nx;
    logic [CNT_W-1:0]  byte_count_nx;
    logic              seq_detect_nx, err_nx, sync_fail_nx;

    logic [31:0]       win_shift, pat_cur;
    logic [2:0]        fill_inc;
    logic [1:0]        req_cur, rep_new;
    logic              match;
    logic [7:0]        exp_byte;
    logic [14:0]       prbs_adv;

    // Pattern/count track the live inputs while hunting, frozen once a match starts the count.
    always_comb begin
        win_shift = {window[23:0], data_in};
        fill_inc  = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
        pat_cur   = (state == HUNT) ? pattern : pat_q;
        req_cur   = (state == HUNT) ? ((n == 2'd0) ? 2'd1 : n) : req_q;
        match     = (fill_inc == 3'd4) && (win_shift == pat_cur);
        rep_new   = (state == HUNT) ? 2'd1 : rep_cnt + 2'd1;
        exp_byte  = {prbs[6:0], prbs[14]};
        prbs_adv  = {prbs[13:0], prbs[14] ^ prbs[13]};
    end

    always_comb begin
        state_nx      = state;
        window_nx     = window;
        fill_nx       = fill;
        rep_cnt_nx    = rep_cnt;
        pat_nx        = pat_q;
        req_nx        = req_q;
        arm_cnt_nx    = arm_cnt;
        miss_cnt_nx   = miss_cnt;
        prbs_nx       = prbs;
        err_count_nx  = err_count;
        byte_count_nx = byte_count;
        seq_detect_nx = 1'b0;
        err_nx        = 1'b0;
        sync_fail_nx  = 1'b0;

        if (en) begin
            window_nx = win_shift;
            unique case (state)
                HUNT, SEQ: begin
                    if (state == HUNT) begin
                        pat_nx = pattern;
                        req_nx = req_cur;
                    end
                    if (match) begin
                        fill_nx       = 3'd0;
                        seq_detect_nx = 1'b1;
                        rep_cnt_nx    = rep_new;
                        if (rep_new >= req_cur) begin
                            state_nx   = ARM;
                            arm_cnt_nx = '0;
                            prbs_nx    = PRBS_SEED;
                        end else begin
                            state_nx = SEQ;
                        end
                    end else begin
                        fill_nx = fill_inc;
                    end
                end
                ARM: begin
                    if (data_in == exp_byte) begin
                        prbs_nx       = prbs_adv;
                        err_count_nx  = '0;
                        byte_count_nx = '0;
                        miss_cnt_nx   = '0;
                        state_nx      = CHECK;
                    end else if (arm_cnt == ARM_LAST) begin
                        sync_fail_nx = 1'b1;
                        state_nx     = HUNT;
                        fill_nx      = 3'd0;
                        rep_cnt_nx   = 2'd0;
                    end else begin
                        arm_cnt_nx = arm_cnt + AW'(1);
                    end
                end
                CHECK: begin
                    prbs_nx = prbs_adv;
                    if (byte_count != '1) byte_count_nx = byte_count + CNT_W'(1);
                    if (data_in != exp_byte) begin
                        err_nx = 1'b1;
                        if (err_count != '1) err_count_nx = err_count + ERR_W'(1);
                        if (miss_cnt == MISS_LAST) begin
                            sync_fail_nx = 1'b1;
                            state_nx     = HUNT;
                            fill_nx      = 3'd0;
                            rep_cnt_nx   = 2'd0;
                        end else begin
                            miss_cnt_nx = miss_cnt + MW'(1);
                        end
                    end else begin
                        miss_cnt_nx = '0;
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= HUNT;
            window     <= '0;
            fill       <= '0;
            rep_cnt    <= '0;
            pat_q      <= '0;
            req_q      <= 2'd1;
            arm_cnt    <= '0;
            miss_cnt   <= '0;
            prbs       <= PRBS_SEED;
            err_count  <= '0;
            byte_count <= '0;
            seq_detect <= 1'b0;
            err        <= 1'b0;
            sync_fail  <= 1'b0;
        end else begin
            state      <= state_nx;
            window     <= window_nx;
            fill       <= fill_nx;
            rep_cnt    <= rep_cnt_nx;
            pat_q      <= pat_nx;
            req_q      <= req_nx;
            arm_cnt    <= arm_cnt_nx;
            miss_cnt   <= miss_cnt_nx;
            prbs       <= prbs_nx;
            err_count  <= err_count_nx;
            byte_count <= byte_count_nx;
            seq_detect <= seq_detect_nx;
            err        <= err_nx;
            sync_fail  <= sync_fail_nx;
        end
    end

    assign locked = (state == CHECK);

endmodule

// File: tb/tb_prbs_seq_checker.sv
// Directed scoreboard bench for prbs_seq_checker: the driver queues the
// hand-derived response for each edge, a monitor pops and compares it.
module tb_prbs_seq_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  data_in;
    logic [31:0] pattern;
    logic [1:0]  n;
    logic        seq_detect, locked, err, sync_fail;
    logic [15:0] err_count;
    logic [23:0] byte_count;

    prbs_seq_checker #(.ERR_W(16), .CNT_W(24), .ARM_TIMEOUT(8), .LOSS_THR(8)) dut (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in), .pattern(pattern), .n(n),
        .seq_detect(seq_detect), .locked(locked), .err(err), .err_count(err_count),
        .byte_count(byte_count), .sync_fail(sync_fail)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sd, lk, er, sf;
        logic [15:0] ec;
        logic [23:0] bc;
    } rec_t;

    rec_t  q[$];
    string nq[$];
    int    total = 0;
    int    bad   = 0;
    logic [15:0] ec_e;
    logic [23:0] bc_e;

    task automatic show_fail(input string nm, input rec_t got, input rec_t want);
        $display("FAIL %s: got sd=%0b lk=%0b err=%0b sf=%0b ec=%0d bc=%0d, want sd=%0b lk=%0b err=%0b sf=%0b ec=%0d bc=%0d",
                 nm, got.sd, got.lk, got.er, got.sf, got.ec, got.bc,
                 want.sd, want.lk, want.er, want.sf, want.ec, want.bc);
    endtask

    function automatic rec_t outs();
        rec_t r;
        r.sd = seq_detect; r.lk = locked; r.er = err; r.sf = sync_fail;
        r.ec = err_count;  r.bc = byte_count;
        return r;
    endfunction

    task automatic send(input logic e, input logic [7:0] d, input logic sd, input logic lk,
                        input logic er, input logic sf, input string nm);
        rec_t r;
        @(negedge clk);
        en = e; data_in = d;
        @(posedge clk);
        r.sd = sd; r.lk = lk; r.er = er; r.sf = sf; r.ec = ec_e; r.bc = bc_e;
        q.push_back(r);
        nq.push_back(nm);
    endtask

    task automatic send_pat(input string nm);
        send(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, {nm, "_a5"});
        send(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, {nm, "_c3"});
        send(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, {nm, "_3c"});
        send(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, {nm, "_match"});
    endtask

    task automatic pulse_reset(input string nm);
        rec_t zero;
        zero = '0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        total++;
        if (outs() !== zero) begin
            bad++;
            show_fail(nm, outs(), zero);
        end
        ec_e = '0; bc_e = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; data_in = 8'h00; pattern = 32'hA5C33C5A; n = 2'd2;
        ec_e = '0; bc_e = '0;

        fork
            forever begin
                rec_t  w;
                string nm;
                @(negedge clk);
                if (q.size() > 0) begin
                    w  = q.pop_front();
                    nm = nq.pop_front();
                    total++;
                    if (outs() !== w) begin
                        bad++;
                        show_fail(nm, outs(), w);
                    end
                end
            end
        join_none

        #12;
        total++;
        if (outs() !== rec_t'(0)) begin
            bad++;
            show_fail("reset_init", outs(), rec_t'(0));
        end
        @(negedge clk);
        rst = 1'b1;

        // Two matches, lock on FF, then clean PRBS with a hold cycle.
        send_pat("t1_m1");
        send_pat("t1_m2");
        send(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, "t1_arm");
        send(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "t1_hold");
        bc_e = 24'd1; send(1'b1, 8'hFD, 1'b0, 1'b1, 1'b0, 1'b0, "t1_fd");
        bc_e = 24'd2; send(1'b1, 8'hF9, 1'b0, 1'b1, 1'b0, 1'b0, "t1_f9");
        bc_e = 24'd3; send(1'b1, 8'hF1, 1'b0, 1'b1, 1'b0, 1'b0, "t1_f1");

        // Eight zero bytes (expected E1 C1 81 01 01 01 01 01) drop lock.
        for (int i = 0; i < 8; i++) begin
            ec_e = ec_e + 16'd1;
            bc_e = bc_e + 24'd1;
            send(1'b1, 8'h00, 1'b0, (i < 7), 1'b1, (i == 7), "t4_zero");
        end
        send(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "t4_idle");

        // Relock with an extra hold byte between matches; counters hold until arming.
        send_pat("t2_m1");
        send(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, "t2_holdbyte");
        send(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, "t2_a5");
        send(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, "t2_c3");
        send(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, "t2_3c");
        send(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, "t2_m2");
        ec_e = '0; bc_e = '0;
        send(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, "t2_arm");
        bc_e = 24'd1; send(1'b1, 8'hFD, 1'b0, 1'b1, 1'b0, 1'b0, "t3_fd");
        bc_e = 24'd2; ec_e = 16'd1; send(1'b1, 8'hF8, 1'b0, 1'b1, 1'b1, 1'b0, "t3_bad_f8");
        bc_e = 24'd3; send(1'b1, 8'hF1, 1'b0, 1'b1, 1'b0, 1'b0, "t3_f1");
        bc_e = 24'd4; send(1'b1, 8'hE1, 1'b0, 1'b1, 1'b0, 1'b0, "t3_e1");
        bc_e = 24'd5; ec_e = 16'd2; send(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, "t6_err2");
        bc_e = 24'd6; ec_e = 16'd3; send(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, "t6_err3");

        // Async reset mid-CHECK, then relock from scratch.
        pulse_reset("t6_rst_mid");
        send_pat("t6_m1");
        send_pat("t6_m2");
        send(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, "t6_arm");
        bc_e = 24'd1; send(1'b1, 8'hFD, 1'b0, 1'b1, 1'b0, 1'b0, "t6_fd");
        bc_e = 24'd2; send(1'b1, 8'hF9, 1'b0, 1'b1, 1'b0, 1'b0, "t6_f9");

        // n=1: one match, eight non-FF bytes time out the arm.
        n = 2'd1;
        pulse_reset("t5_rst");
        send_pat("t5_m1");
        for (int i = 0; i < 8; i++)
            send(1'b1, 8'h12, 1'b0, 1'b0, 1'b0, (i == 7), "t5_arm_to");
        send(1'b0, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, "t5_idle");

        // n=0 behaves as n=1.
        n = 2'd0;
        send_pat("t7_m1");
        send(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, "t7_arm");
        bc_e = 24'd1; send(1'b1, 8'hFD, 1'b0, 1'b1, 1'b0, 1'b0, "t7_fd");
        send(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "t7_hold");

        @(negedge clk);
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected responses left, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
